// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if -- request/response handshake between the pipeline MEM stage and
// the load/store unit.
//
// Signals:
//   req_valid   pipeline request present
//   req_ready   load/store unit can accept a request
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I size/sign code (B, H, W, BU, HU)
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   load result (0 for stores and errors)
//   rsp_err     request rejected
//
// Modports:
//   master  pipeline side
//   slave   load/store unit side
// ---------------------------------------------------------------------------
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store unit between the MEM stage and a word-only data
// memory with a 1-cycle registered read. Byte/halfword loads are extracted
// and extended here; SB/SH are built by read-modify-write. Every accepted
// request gets exactly one rsp_valid pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   lsu       lsu_if.slave request/response handshake
//   mem_ad    word-aligned byte address to the data memory
//   writ_dat  write word to the data memory
//   mem_wrt   data memory write enable
//   red_dat   data memory read data (valid the cycle after mem_ad)
//
// Parameter:
//   WORDS     data memory depth in 32-bit words
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined: misaligned H/HU/SH/W/SW are rejected.
//                         undefined: low address bits are simply truncated.
//
// All outputs are registered. Memory-side outputs are loaded on entry to
// RD/WR so they are valid during that state; the response outputs are loaded
// when leaving RESP/ERR, so rsp_valid is high in the cycle after those states.
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        lsu,
    output logic [31:0] mem_ad,
    output logic [31:0] writ_dat,
    output logic        mem_wrt,
    input  logic [31:0] red_dat
);

    typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, RESP, ERR} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;   // only the sub-word part is needed after accept
    logic [31:0] rdata_q;

    logic funct3_bad;
    logic range_bad;
    logic misalign;
    logic req_err;

    // Extract a byte/halfword from a memory word and sign/zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    // Merge SB/SH store data into the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] wd,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  funct3);
        logic [31:0] res;
        res = word;
        if (funct3[0] == 1'b0) begin
            case (lane)
                2'd0:    res[7:0]   = wd[7:0];
                2'd1:    res[15:8]  = wd[7:0];
                2'd2:    res[23:16] = wd[7:0];
                default: res[31:24] = wd[7:0];
            endcase
        end else if (lane[1]) begin
            res[31:16] = wd;
        end else begin
            res[15:0] = wd;
        end
        return res;
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first so no
    // latch is inferred.
    always_comb begin
        funct3_bad = 1'b0;
        case (lsu.req_funct3)
            3'b011, 3'b110, 3'b111: funct3_bad = 1'b1;
            default:                funct3_bad = 1'b0;
        endcase
        // Stores only exist as SB/SH/SW.
        if (lsu.req_we && lsu.req_funct3[2])
            funct3_bad = 1'b1;
    end

    assign range_bad = {2'b00, lsu.req_addr[31:2]} >= 32'(WORDS);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((lsu.req_funct3[1:0] == 2'b01) && lsu.req_addr[0]) ||
                      ((lsu.req_funct3[1:0] == 2'b10) && (lsu.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = funct3_bad || range_bad || misalign;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 16'd0;
            rdata_q       <= 32'd0;
            lsu.req_ready <= 1'b1;
            lsu.rsp_valid <= 1'b0;
            lsu.rsp_rdata <= 32'd0;
            lsu.rsp_err   <= 1'b0;
            mem_ad        <= 32'd0;
            writ_dat      <= 32'd0;
            mem_wrt       <= 1'b0;
        end else begin
            lsu.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        we_q          <= lsu.req_we;
                        funct3_q      <= lsu.req_funct3;
                        addr_q        <= lsu.req_addr;
                        wdata_q       <= lsu.req_wdata[15:0];
                        rdata_q       <= 32'd0;
                        lsu.req_ready <= 1'b0;
                        if (req_err) begin
                            state <= ERR;
                        end else if (lsu.req_we && lsu.req_funct3 == 3'b010) begin
                            state    <= WR;
                            mem_ad   <= {lsu.req_addr[31:2], 2'b00};
                            writ_dat <= lsu.req_wdata;
                            mem_wrt  <= 1'b1;
                        end else begin
                            state  <= RD;
                            mem_ad <= {lsu.req_addr[31:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    // Memory samples mem_ad at this edge; data arrives in RD_DATA.
                    state  <= RD_DATA;
                    mem_ad <= 32'd0;
                end
                RD_DATA: begin
                    if (we_q) begin
                        state    <= WR;
                        mem_ad   <= {addr_q[31:2], 2'b00};
                        writ_dat <= store_merge(red_dat, wdata_q, addr_q[1:0], funct3_q);
                        mem_wrt  <= 1'b1;
                    end else begin
                        state   <= RESP;
                        rdata_q <= load_extract(red_dat, addr_q[1:0], funct3_q);
                    end
                end
                WR: begin
                    state    <= RESP;
                    mem_ad   <= 32'd0;
                    writ_dat <= 32'd0;
                    mem_wrt  <= 1'b0;
                end
                RESP: begin
                    state         <= IDLE;
                    lsu.req_ready <= 1'b1;
                    lsu.rsp_valid <= 1'b1;
                    lsu.rsp_err   <= 1'b0;
                    lsu.rsp_rdata <= we_q ? 32'd0 : rdata_q;
                end
                ERR: begin
                    state         <= IDLE;
                    lsu.req_ready <= 1'b1;
                    lsu.rsp_valid <= 1'b1;
                    lsu.rsp_err   <= 1'b1;
                    lsu.rsp_rdata <= 32'd0;
                end
                default: begin
                    state         <= IDLE;
                    lsu.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- directed self-checking bench for lsu_ctrl. A behavioural
// word memory with a 1-cycle registered read stands in for datmem.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_ad;
    logic [31:0] writ_dat;
    logic        mem_wrt;
    logic [31:0] red_dat = 32'd0;

    lsu_if bus ();

    lsu_ctrl #(.WORDS(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lsu      (bus),
        .mem_ad   (mem_ad),
        .writ_dat (writ_dat),
        .mem_wrt  (mem_wrt),
        .red_dat  (red_dat)
    );

    always #5 clk = ~clk;

    // Behavioural data memory plus write monitor.
    logic [31:0] mem [64];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          wr_edge = 0;
    logic [31:0] last_wdat = 32'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wrt) begin
            mem[mem_ad[7:2]] <= writ_dat;
            wr_cnt           <= wr_cnt + 1;
            wr_edge          <= cyc + 1;
            last_wdat        <= writ_dat;
        end
        red_dat <= mem[mem_ad[7:2]];
    end

    int n_checks = 0;
    int n_fail = 0;
    int acc_edge = 0;
    int wr_delta = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and check the response arrives exactly 'lat' edges
    // after the accept edge, with the expected data and error flag.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int lat,
                          input logic [31:0] exp_rd, input logic exp_err);
        int wr_base;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        wr_base        = wr_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        acc_edge      = cyc;
        bus.req_valid = 1'b0;
        for (int n = 0; n <= lat; n++) begin
            @(negedge clk);
            if (n < lat) begin
                check({tag, "_early"}, {31'd0, bus.rsp_valid}, 32'd0);
            end else begin
                check({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
                check({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
                check({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
            end
        end
        wr_delta = wr_cnt - wr_base;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_mem_ad", mem_ad, 32'd0);
        check("rst_writ_dat", writ_dat, 32'd0);
        check("rst_mem_wrt", {31'd0, mem_wrt}, 32'd0);
        rst_n = 1'b1;

        // Preload word 0x8 through the unit itself.
        do_req("sw_pre", 1'b1, 3'b010, 32'h8, 32'h8000FF7F, 2, 32'd0, 1'b0);
        check("sw_pre_writes", wr_delta, 1);
        check("sw_pre_mem", mem[2], 32'h8000FF7F);

        // Sub-word loads from 0x8000FF7F.
        do_req("lb_8", 1'b0, 3'b000, 32'h8, 32'd0, 3, 32'h0000007F, 1'b0);
        check("lb_8_writes", wr_delta, 0);
        do_req("lb_9", 1'b0, 3'b000, 32'h9, 32'd0, 3, 32'hFFFFFFFF, 1'b0);
        check("lb_9_writes", wr_delta, 0);
        do_req("lbu_9", 1'b0, 3'b100, 32'h9, 32'd0, 3, 32'h000000FF, 1'b0);
        check("lbu_9_writes", wr_delta, 0);
        do_req("lh_a", 1'b0, 3'b001, 32'hA, 32'd0, 3, 32'hFFFF8000, 1'b0);
        check("lh_a_writes", wr_delta, 0);
        do_req("lhu_a", 1'b0, 3'b101, 32'hA, 32'd0, 3, 32'h00008000, 1'b0);
        check("lhu_a_writes", wr_delta, 0);

        // SB into the top byte lane: one write, committed at accept edge + 3.
        do_req("sb_b", 1'b1, 3'b000, 32'hB, 32'h00000012, 4, 32'd0, 1'b0);
        check("sb_b_writes", wr_delta, 1);
        check("sb_b_wr_edge", wr_edge - acc_edge, 3);
        check("sb_b_writ_dat", last_wdat, 32'h1200FF7F);
        check("sb_b_mem", mem[2], 32'h1200FF7F);

        // SW then LW back.
        do_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'd0, 1'b0);
        check("sw_10_writes", wr_delta, 1);
        do_req("lw_10", 1'b0, 3'b010, 32'h10, 32'd0, 3, 32'hDEADBEEF, 1'b0);
        repeat (2) @(negedge clk);
        check("lw_10_hold", bus.rsp_rdata, 32'hDEADBEEF);

        // Misaligned halfword load.
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lh_9", 1'b0, 3'b001, 32'h9, 32'd0, 1, 32'd0, 1'b1);
`else
        do_req("lh_9", 1'b0, 3'b001, 32'h9, 32'd0, 3, 32'hFFFFFF7F, 1'b0);
`endif
        check("lh_9_writes", wr_delta, 0);

        // Range and funct3 errors.
        do_req("lw_range", 1'b0, 3'b010, 32'h100, 32'd0, 1, 32'd0, 1'b1);
        do_req("f3_011", 1'b0, 3'b011, 32'h0, 32'd0, 1, 32'd0, 1'b1);
        do_req("sb_f3_100", 1'b1, 3'b100, 32'h8, 32'h000000AA, 1, 32'd0, 1'b1);
        check("sb_f3_100_writes", wr_delta, 0);
        check("sb_f3_100_mem", mem[2], 32'h1200FF7F);

        // Reset during RD_DATA of an SB: dropped, nothing written.
        begin
            int wr_base;
            @(negedge clk);
            wr_base        = wr_cnt;
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b1;
            bus.req_funct3 = 3'b000;
            bus.req_addr   = 32'hB;
            bus.req_wdata  = 32'h00000055;
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
            check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            check("mid_rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
            check("mid_rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            check("mid_rst_mem_ad", mem_ad, 32'd0);
            check("mid_rst_writ_dat", writ_dat, 32'd0);
            check("mid_rst_mem_wrt", {31'd0, mem_wrt}, 32'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            check("mid_rst_writes", wr_cnt - wr_base, 0);
            check("mid_rst_mem", mem[2], 32'h1200FF7F);
            check("mid_rst_ready_after", {31'd0, bus.req_ready}, 32'd1);
            check("mid_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the pipeline MEM stage and the word-only data memory (datmem).
- Data memory has a 1-cycle registered read, full-word writes only and ignores addr[1:0].
- This block issues memory accesses on the pipeline's behalf:
  - extracts and sign/zero-extends byte/halfword loads,
  - builds SB/SH via read-modify-write,
  - checks range and alignment,
  - returns one response pulse per request.

Parameters:
- WORDS, 64: data memory depth in 32-bit words; word index >= WORDS is an error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected: misaligned, out of range or illegal funct3.
- mem_ad  out  32  byte address to datmem, [1:0] always 00.
- writ_dat  out  32  write word to datmem.
- mem_wrt  out  1  datmem write enable.
- red_dat  in  32  datmem read data, valid the cycle after the address is presented.

Behaviour:
- Reset (rst_n low, async):
  - state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_ad=0, writ_dat=0, mem_wrt=0.
  - Request registers cleared.
- States: IDLE, RD, RD_DATA, WR, RESP, ERR.
- Outputs:
  - req_ready=1 only in IDLE.
  - mem_wrt=1 only in WR.
  - writ_dat=0 outside WR.
  - mem_ad={addr_q[31:2],2'b00} in RD/WR, else 0.
- IDLE, on req_valid&req_ready: register we/funct3/addr/wdata, then:
  - Error (illegal funct3 011/110/111, or for stores funct3 with bit2 set; addr[31:2]>=WORDS; misalignment per optional feature) -> ERR.
  - SW -> WR.
  - All loads, SB, SH -> RD.
- RD: present address, mem_wrt=0 -> RD_DATA.
- RD_DATA: red_dat valid.
  - Load: select byte addr[1:0] / halfword addr[1]; sign-extend (B/H) or zero-extend (BU/HU/W); register into rsp_rdata -> RESP.
  - SB/SH: merge wdata[7:0]/[15:0] into red_dat at byte lane; register merged word -> WR.
- WR: writ_dat=merged word (SB/SH) or wdata_q (SW), mem_wrt=1 for exactly one cycle -> RESP.
- RESP: rsp_valid=1 for one cycle, rsp_err=0 -> IDLE.
- ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0, no memory access -> IDLE.
- Latency, counted from accept edge k, rsp_valid high during the cycle after:
  - loads edge k+3;
  - SW edge k+2;
  - SB/SH edge k+4;
  - errors edge k+1.
- No back-to-back acceptance: next accept earliest the cycle after rsp_valid.
- No response backpressure; rsp_valid is a pulse.
- rsp_rdata/rsp_err hold their value until the next response.
- req_valid while req_ready=0 is ignored; the pipeline holds it.
- Reset mid-operation:
  - Access is dropped; no response.
  - A store reset before WR never writes.
  - A store reset in WR has completed at most its single write.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1 -> ERR.
  - LW/SW with addr[1:0]!=0 -> ERR.
- Undefined:
  - No misalignment error.
  - Halfword offset forced to addr[1]&~addr[0]... i.e. low address bits truncated (H uses addr[1], W ignores addr[1:0]); access proceeds normally.
- Range and funct3 errors apply in both builds.

Test Plan:
- Preload word 0x8=0x8000FF7F, then LB/LB/LBU/LH/LHU:
  - LB 0x8 -> 0x0000007F
  - LB 0x9 -> 0xFFFFFFFF
  - LBU 0x9 -> 0x000000FF
  - LH 0xA -> 0xFFFF8000
  - LHU 0xA -> 0x00008000
  - Each rsp_valid at accept+3, mem_wrt never high.
- SB addr 0xB wdata 0x00000012 -> mem_wrt high exactly once at accept+3 with writ_dat=0x1200FF7F; rsp_valid at accept+4, rsp_err=0.
- SW 0x10 0xDEADBEEF (rsp at accept+2), then LW 0x10 -> rsp_rdata=0xDEADBEEF.
- LH 0x9:
  - with LSU_MISALIGN_TRAP_EN -> rsp_err=1 at accept+1, rsp_rdata=0, no mem access.
  - without -> rsp_rdata=0xFFFFFF7F (halfword at 0x8).
- LW 0x100 (word 64) and funct3=011 -> rsp_err=1 at accept+1; SB funct3=100 -> rsp_err=1.
- SB 0xB in flight, rst_n low during RD_DATA -> all outputs 0 immediately, mem_wrt never asserted, word 0x8 unchanged, req_ready=1 after release.
